c17_response_misr: RTL and testbench
====================================

// Module: c17_response_misr
// PURPOSE
//  Downstream response compactor for the c17 benchmark wrapper. Samples the registered
//  outputs {N23,N22} every enabled clock, discards the pipeline fill cycles and folds the
//  rest into a multiple-input signature register (MISR). After a fixed window it compares
//  the signature with a golden value and raises error. Drives c17's en and consumes N22/N23.
// PARAMETERS
//  RESP_W  2        response bits per cycle; resp_in = {N23,N22}
//  SIG_W   16       signature width; must satisfy SIG_W > RESP_W
//  POLY    16'h1021 Galois feedback polynomial, x^SIG_W term implicit
//  SEED    16'h0000 signature value loaded on start
//  SKIP    2        enabled cycles discarded after start (c17 in->out register latency)
//  WINDOW  8192     enabled cycles compacted (16384 ns run / 2 ns clock period)
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  en          in   1       cycle qualifier; en=0 freezes all counting and compaction
//  start       in   1       single-cycle pulse; accepted in IDLE or DONE only
//  resp_in     in   RESP_W  c17 outputs {N23,N22}, already registered upstream
//  golden_sig  in   SIG_W   expected signature; must be stable from start until done
//  sig_out     out  SIG_W   current signature register
//  cycle_cnt   out  16      enabled cycles consumed in the current phase
//  busy        out  1       high in PRIME or RUN
//  done        out  1       level, high in DONE
//  error       out  1       level, valid while done=1 (1 = signature mismatch)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, sig_out=SEED, cycle_cnt=0, busy=0,
//    done=0, error=0. Asserting rst_n mid-run aborts with no done pulse and no error.
//  - FSM: IDLE -start-> PRIME: load sig=SEED, cnt=0.
//    PRIME, en=1: cnt++; when cnt==SKIP-1 -> RUN, cnt=0. With SKIP=0, start goes directly to RUN.
//    RUN, en=1: sig<=misr(sig,resp_in), cnt++; when cnt==WINDOW-1 -> DONE and
//    error <= (misr(sig,resp_in) != golden_sig), i.e. the final absorb is included.
//    DONE: hold sig_out, error, and cycle_cnt=WINDOW-1; start -> PRIME (restart, error cleared).
//  - en=0 in any state: state, sig, and cnt hold. start is ignored while en=0.
//  - start in PRIME or RUN is ignored; it never restarts a run.
//  - misr(s,r) = {s[SIG_W-2:0],1'b0} ^ (s[SIG_W-1] ? POLY : 0) ^ zero-extended r.
//  - cycle_cnt is 16 bits and never wraps within a phase. WINDOW <= 65536 and SKIP <= 65536.
//  - Latency: done and error rise on the clock after the WINDOW-th enabled RUN cycle.
//  - Purely synchronous datapath; there are no combinational paths from inputs to outputs.
// STRUCTURE
//  - Package c17_bist_pkg: state enum {IDLE,PRIME,RUN,DONE}, default POLY/SEED constants,
//    and the misr() function shared with the upstream pattern generator's LFSR.
//  - One sub-module misr_core (SIG_W, RESP_W, POLY): ports clk, rst_n, load, seed,
//    shift, din, and sig. FSM and counter stay in the top.
// TESTING
//  1 SEED=0, resp_in=0 for the whole run, golden=0 -> done after SKIP+WINDOW enabled
//    cycles, sig_out=0x0000, error=0.
//  2 WINDOW=3, SKIP=2, resp_in=2'b01 constant -> sig 0x0001, 0x0003, 0x0007.
//    golden=0x0007 gives error=0; golden=0x0006 gives error=1.
//  3 Toggle en=0 for 5 cycles mid-RUN -> sig_out and cycle_cnt frozen, and the final
//    signature is identical to an uninterrupted run.
//  4 Pulse start in RUN at cnt=100 -> ignored, with cnt continuing 101, 102, ...
//    Pulse start in DONE -> PRIME, error=0, and sig_out=SEED on the next clock.
//  5 Drive rst_n low mid-RUN (asynchronously, between edges) -> outputs go to reset
//    values immediately, and done never pulses.
//  6 Connect to the c17 block driven with the 2/4/6/8/10 ns toggling inputs, capture the
//    golden signature, then inject a stuck-at-0 on N16 -> error=1 at done.

Source files
------------

// File: rtl/c17_bist_pkg.sv
// Shared definitions for the c17 BIST wrapper: FSM state set, default polynomial/seed,
// and the Galois step used by both the response MISR and the pattern LFSR.
package c17_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned SIG_MAX  = 64;
    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    // One Galois shift of a w-bit register with parallel input r folded in.
    // With r=0 this is the plain LFSR step used by the pattern generator.
    function automatic logic [SIG_MAX-1:0] misr(
        input logic [SIG_MAX-1:0] s,
        input logic [SIG_MAX-1:0] r,
        input logic [SIG_MAX-1:0] poly,
        input int unsigned        w
    );
        logic [SIG_MAX-1:0] mask;
        logic [SIG_MAX-1:0] fb;
        mask = (w >= SIG_MAX) ? '1 : ((SIG_MAX'(1) << w) - SIG_MAX'(1));
        fb   = s[w-1] ? poly : '0;
        misr = ((s << 1) ^ fb ^ r) & mask;
    endfunction

endpackage

// File: rtl/c17_response_misr_if.sv
// Control, response and status bundle between the c17 wrapper and the response compactor.
interface c17_response_misr_if #(
    parameter int RESP_W = 2,
    parameter int SIG_W  = 16
);
    logic              en;
    logic              start;
    logic [RESP_W-1:0] resp_in;
    logic [SIG_W-1:0]  golden_sig;
    logic [SIG_W-1:0]  sig_out;
    logic [15:0]       cycle_cnt;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output en, start, resp_in, golden_sig,
        input  sig_out, cycle_cnt, busy, done, error
    );

    modport slave (
        input  en, start, resp_in, golden_sig,
        output sig_out, cycle_cnt, busy, done, error
    );
endinterface

// File: rtl/c17_response_misr_core.sv
// Signature register: load has priority over shift; one absorb per shift cycle.
module misr_core
    import c17_bist_pkg::*;
#(
    parameter int              SIG_W  = 16,
    parameter int              RESP_W = 2,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [SIG_W-1:0]  seed,
    input  logic              shift,
    input  logic [RESP_W-1:0] din,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_next;

    assign sig_next = SIG_W'(misr(SIG_MAX'(sig), SIG_MAX'(din), SIG_MAX'(POLY), SIG_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= seed;
        end else if (shift) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/c17_response_misr.sv
// Response compactor: drops SKIP fill cycles, folds WINDOW responses into a MISR, then
// compares against golden_sig. All outputs are registered or decoded from registered state.
module c17_response_misr
    import c17_bist_pkg::*;
#(
    parameter int               RESP_W = 2,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED   = DEF_SEED,
    parameter int               SKIP   = 2,
    parameter int               WINDOW = 8192
) (
    input  logic                clk,
    input  logic                rst_n,
    c17_response_misr_if.slave  bus
);

    localparam logic [1:0]  S_IDLE    = IDLE;
    localparam logic [1:0]  S_PRIME   = PRIME;
    localparam logic [1:0]  S_RUN     = RUN;
    localparam logic [1:0]  S_DONE    = DONE;
    localparam logic [15:0] SKIP_LAST = 16'(SKIP - 1);
    localparam logic [15:0] WIN_LAST  = 16'(WINDOW - 1);

    if (SIG_W <= RESP_W || SIG_W > SIG_MAX || WINDOW < 1 || WINDOW > 65536 ||
        SKIP < 0 || SKIP > 65536) begin : g_param_check
        $error("c17_response_misr: illegal parameter combination");
    end

    logic [1:0]       state;
    logic [15:0]      cnt;
    logic             err_q;
    logic             accept_start;
    logic             absorb;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_next;

    assign accept_start = bus.en && bus.start && (state == S_IDLE || state == S_DONE);
    assign absorb       = bus.en && (state == S_RUN);

    // Same absorb the core performs this cycle, so the final compare includes it.
    assign sig_next = SIG_W'(misr(SIG_MAX'(sig), SIG_MAX'(bus.resp_in), SIG_MAX'(POLY), SIG_W));

    misr_core #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_start),
        .seed  (SEED),
        .shift (absorb),
        .din   (bus.resp_in),
        .sig   (sig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
            err_q <= 1'b0;
        end else if (bus.en) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        cnt   <= 16'd0;
                        err_q <= 1'b0;
                        state <= (SKIP == 0) ? S_RUN : S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (cnt == SKIP_LAST) begin
                        cnt   <= 16'd0;
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    // cnt parks at WINDOW-1 in DONE rather than wrapping.
                    if (cnt == WIN_LAST) begin
                        err_q <= (sig_next != bus.golden_sig);
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sig_out   = sig;
    assign bus.cycle_cnt = cnt;
    assign bus.busy      = (state == S_PRIME) || (state == S_RUN);
    assign bus.done      = (state == S_DONE);
    assign bus.error     = err_q;

endmodule

// File: tb/tb_c17_response_misr.sv
// Directed/randomized bench for c17_response_misr: three instances with different windows,
// checked against a polynomial-arithmetic signature model.
module tb_c17_response_misr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  resp = 2'b00;
    logic        start_v [3];
    logic [15:0] golden_v [3];
    logic [15:0] sig_o [3];
    logic [15:0] cnt_o [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic        err_o [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c17_response_misr_if #(.RESP_W(2), .SIG_W(16)) ifa ();
    c17_response_misr_if #(.RESP_W(2), .SIG_W(16)) ifb ();
    c17_response_misr_if #(.RESP_W(2), .SIG_W(16)) ifc ();

    assign ifa.en = en;  assign ifa.start = start_v[0];
    assign ifb.en = en;  assign ifb.start = start_v[1];
    assign ifc.en = en;  assign ifc.start = start_v[2];
    assign ifa.resp_in = resp;  assign ifa.golden_sig = golden_v[0];
    assign ifb.resp_in = resp;  assign ifb.golden_sig = golden_v[1];
    assign ifc.resp_in = resp;  assign ifc.golden_sig = golden_v[2];

    assign sig_o[0] = ifa.sig_out; assign cnt_o[0] = ifa.cycle_cnt;
    assign busy_o[0] = ifa.busy;   assign done_o[0] = ifa.done; assign err_o[0] = ifa.error;
    assign sig_o[1] = ifb.sig_out; assign cnt_o[1] = ifb.cycle_cnt;
    assign busy_o[1] = ifb.busy;   assign done_o[1] = ifb.done; assign err_o[1] = ifb.error;
    assign sig_o[2] = ifc.sig_out; assign cnt_o[2] = ifc.cycle_cnt;
    assign busy_o[2] = ifc.busy;   assign done_o[2] = ifc.done; assign err_o[2] = ifc.error;

    c17_response_misr #(.SKIP(2), .WINDOW(8192)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    c17_response_misr #(.SKIP(2), .WINDOW(3))    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    c17_response_misr #(.SKIP(2), .WINDOW(200))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Signature as polynomial arithmetic: multiply by x modulo x^16+x^12+x^5+1, add response.
    function automatic logic [15:0] step(input logic [15:0] s, input logic [1:0] r);
        int unsigned v;
        v = 32'(s) * 2;
        if (v >= 32'h10000) v = v ^ 32'h11021;
        return 16'(v ^ 32'(r));
    endfunction

    function automatic logic [15:0] sig_of(input logic [1:0] rs[$]);
        logic [15:0] s = 16'h0000;
        foreach (rs[i]) s = step(s, rs[i]);
        return s;
    endfunction

    // c17 gate network; inputs toggle every 1..5 cycles (2/4/6/8/10 ns at a 2 ns clock).
    function automatic logic [1:0] c17(input int t, input bit n16_sa0);
        bit n1, n2, n3, n6, n7, n10, n11, n16, n19;
        n1 = ((t / 1) % 2) == 1;  n2 = ((t / 2) % 2) == 1;  n3 = ((t / 3) % 2) == 1;
        n6 = ((t / 4) % 2) == 1;  n7 = ((t / 5) % 2) == 1;
        n10 = !(n1 && n3);
        n11 = !(n3 && n6);
        n16 = n16_sa0 ? 1'b0 : !(n2 && n11);
        n19 = !(n11 && n7);
        return {!(n16 && n19), !(n10 && n16)};
    endfunction

    task automatic tick(input logic e, input int d, input logic s, input logic [1:0] r);
        @(negedge clk);
        en = e;
        resp = r;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        if (d >= 0) start_v[d] = s;
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int d, input logic [1:0] rs[$], input int pause_at, input int poke_at);
        logic [15:0] s;
        logic [15:0] snap_s;
        logic [15:0] snap_c;
        int n;
        n = rs.size();
        s = 16'h0000;
        tick(1'b1, d, 1'b1, 2'b00);
        chk("start_busy", 32'(busy_o[d]), 32'd1);
        chk("start_done", 32'(done_o[d]), 32'd0);
        chk("start_err",  32'(err_o[d]),  32'd0);
        chk("start_sig",  32'(sig_o[d]),  32'h0000);
        chk("start_cnt",  32'(cnt_o[d]),  32'd0);
        tick(1'b1, d, 1'b0, 2'($urandom));
        chk("prime_cnt",  32'(cnt_o[d]),  32'd1);
        chk("prime_sig",  32'(sig_o[d]),  32'h0000);
        tick(1'b1, d, 1'b0, 2'($urandom));
        chk("prime_exit", 32'(cnt_o[d]),  32'd0);
        chk("prime_busy", 32'(busy_o[d]), 32'd1);
        for (int k = 0; k < n; k++) begin
            if (k == pause_at) begin
                snap_s = sig_o[d];
                snap_c = cnt_o[d];
                repeat (5) begin
                    tick(1'b0, d, 1'b1, 2'($urandom));
                    chk("pause_sig", 32'(sig_o[d]), 32'(snap_s));
                    chk("pause_cnt", 32'(cnt_o[d]), 32'(snap_c));
                end
            end
            tick(1'b1, d, (k == poke_at), rs[k]);
            s = step(s, rs[k]);
            chk("run_sig",  32'(sig_o[d]),  32'(s));
            chk("run_cnt",  32'(cnt_o[d]),  (k < n - 1) ? 32'(k + 1) : 32'(n - 1));
            chk("run_done", 32'(done_o[d]), 32'(k == n - 1));
        end
        chk("end_busy", 32'(busy_o[d]), 32'd0);
    endtask

    initial begin
        logic [1:0]  rs[$];
        logic [1:0]  bad[$];
        logic [15:0] g;
        int          done_seen;

        for (int i = 0; i < 3; i++) begin
            start_v[i]  = 1'b0;
            golden_v[i] = 16'h0000;
        end

        // Reset state
        #12;
        chk("rst_sig",  32'(sig_o[0]),  32'h0000);
        chk("rst_cnt",  32'(cnt_o[0]),  32'd0);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_done", 32'(done_o[0]), 32'd0);
        chk("rst_err",  32'(err_o[0]),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WINDOW=3, constant 01: 0x0001, 0x0003, 0x0007
        rs = '{2'b01, 2'b01, 2'b01};
        golden_v[1] = 16'h0007;
        run(1, rs, -1, -1);
        chk("w3_sig",      32'(sig_o[1]), 32'h0007);
        chk("w3_err_good", 32'(err_o[1]), 32'd0);
        golden_v[1] = 16'h0006;
        run(1, rs, -1, -1);
        chk("w3_err_bad",  32'(err_o[1]), 32'd1);

        // Random window of 200, uninterrupted then with en gap and start poke in RUN
        rs.delete();
        for (int k = 0; k < 200; k++) rs.push_back(2'($urandom));
        g = sig_of(rs);
        golden_v[2] = g;
        run(2, rs, -1, -1);
        chk("w200_sig", 32'(sig_o[2]), 32'(g));
        chk("w200_err", 32'(err_o[2]), 32'd0);
        golden_v[2] = g ^ 16'h0001;
        run(2, rs, 50, 100);
        chk("gap_sig", 32'(sig_o[2]), 32'(g));
        chk("gap_err", 32'(err_o[2]), 32'd1);
        chk("gap_cnt_hold", 32'(cnt_o[2]), 32'd199);

        // Restart from DONE, then async reset mid-RUN
        tick(1'b1, 2, 1'b1, 2'b11);
        chk("restart_sig",  32'(sig_o[2]),  32'h0000);
        chk("restart_err",  32'(err_o[2]),  32'd0);
        chk("restart_busy", 32'(busy_o[2]), 32'd1);
        chk("restart_done", 32'(done_o[2]), 32'd0);
        repeat (2) tick(1'b1, 2, 1'b0, 2'($urandom));
        repeat (30) tick(1'b1, 2, 1'b0, 2'b11);
        chk("pre_rst_cnt", 32'(cnt_o[2]), 32'd30);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sig",  32'(sig_o[2]),  32'h0000);
        chk("arst_cnt",  32'(cnt_o[2]),  32'd0);
        chk("arst_busy", 32'(busy_o[2]), 32'd0);
        chk("arst_done", 32'(done_o[2]), 32'd0);
        chk("arst_err",  32'(err_o[2]),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (300) begin
            tick(1'b1, -1, 1'b0, 2'($urandom));
            if (done_o[2] !== 1'b0) done_seen++;
        end
        chk("arst_no_done", 32'(done_seen), 32'd0);
        chk("arst_idle",    32'(busy_o[2]), 32'd0);

        // Full 8192-cycle window, all-zero responses
        rs.delete();
        for (int k = 0; k < 8192; k++) rs.push_back(2'b00);
        golden_v[0] = 16'h0000;
        run(0, rs, -1, -1);
        chk("zero_sig", 32'(sig_o[0]), 32'h0000);
        chk("zero_err", 32'(err_o[0]), 32'd0);

        // c17 responses: golden from fault-free model, then N16 stuck-at-0
        rs.delete();
        bad.delete();
        for (int k = 0; k < 8192; k++) begin
            rs.push_back(c17(k + 2, 1'b0));
            bad.push_back(c17(k + 2, 1'b1));
        end
        g = sig_of(rs);
        golden_v[0] = g;
        run(0, rs, -1, -1);
        chk("c17_good_err", 32'(err_o[0]), 32'd0);
        run(0, bad, -1, -1);
        chk("c17_sa0_sig", 32'(sig_o[0]), 32'(sig_of(bad)));
        chk("c17_sa0_err", 32'(err_o[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
